stopwatch_controller: RTL and testbench
=======================================

// Module: stopwatch_controller
// PURPOSE
//   Sequences the MM:SS stopwatch datapath that feeds the 4-digit display controller.
//   Conditions three push-buttons and runs an IDLE/RUN/PAUSE state machine.
//   Divides clk down to a 1 Hz tick and keeps a BCD minutes:seconds count.
//   Drives digit0..digit3 (ones-sec, tens-sec, ones-min, tens-min) directly into the display controller.
// PARAMETERS
//   TICK_DIV        100_000_000  clk cycles per counted second (the sim bench uses 10)
//   DEBOUNCE_CYCLES 1_000_000    clk cycles a synced button level must stay stable to be accepted (the sim bench uses 4)
// PORTS
//   clk         in   1  system clock; all logic is in this one domain
//   rst_n       in   1  asynchronous, active-low reset
//   btn_start   in   1  raw start/stop button, active high, asynchronous to clk
//   btn_lap     in   1  raw lap button, active high, asynchronous to clk
//   btn_clear   in   1  raw clear button, active high, asynchronous to clk
//   digit0      out  4  BCD ones of seconds (0-9)
//   digit1      out  4  BCD tens of seconds (0-5)
//   digit2      out  4  BCD ones of minutes (0-9)
//   digit3      out  4  BCD tens of minutes (0-5)
//   running     out  1  high while the state is RUN
//   lap_active  out  1  high while the display is frozen on a lap value
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): state=IDLE, count=00:00, lap latch=00:00, prescaler=0.
//     Debouncers are released (accepted level 0). digit0..3=0, running=0, lap_active=0.
//     Reset asserted mid-RUN or mid-PAUSE aborts immediately. No press event is produced on release.
//   Button conditioning, per button:
//     2-FF synchronizer feeds a debounce counter.
//     The accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synced level.
//     Any bounce inside that window restarts the counter.
//     Press event = 1-cycle pulse on an accepted 0->1 transition. Releases and holds generate nothing.
//     Raw edge -> press pulse latency is 2 + DEBOUNCE_CYCLES cycles.
//   FSM, evaluated on press events:
//     IDLE : start -> RUN. lap and clear are ignored.
//     RUN  : start -> PAUSE. lap toggles lap_active. clear is ignored.
//     PAUSE: start -> RUN.
//            clear -> IDLE; count, lap latch and lap_active are zeroed.
//            lap with lap_active=1 -> lap_active=0; with lap_active=0 -> ignored.
//   Same-cycle press priority: clear > start > lap. A lower-priority press that loses is discarded, not queued.
//   Prescaler: counts 0..TICK_DIV-1 only while in RUN.
//     tick = (prescaler==TICK_DIV-1 && RUN); the prescaler then wraps to 0.
//     Holds its value in PAUSE, so resume keeps the fractional second. Zeroed on entering IDLE.
//   BCD count, advanced on the clk edge where tick=1:
//     s_ones 9->0 carries to s_tens; s_tens 5->0 carries to m_ones; m_ones 9->0 carries to m_tens; m_tens 5->0.
//     59:59 + tick -> 00:00 with no flag and no stop.
//     Invalid BCD codes are unreachable; no recovery logic is required.
//   tick coinciding with a start press in RUN: the tick is applied, then the state goes to PAUSE.
//   Lap: on the cycle lap_active goes 0->1, the lap latch captures the count value after that cycle's tick.
//   digit0..3 = lap_active ? lap latch : live count.
//     Outputs are registered or a mux of registers only; no combinational path from the buttons.
//     A tick at edge N is visible on the digits after edge N (0 extra cycles).
//   running and lap_active are registered state bits that change on the same edge as the FSM.
// TESTING (bench params: TICK_DIV=10, DEBOUNCE_CYCLES=4)
//   1. Reset, then press start and hold 5 cycles -> running=1 after 7 cycles; digit0=1 at 10 cycles after entering RUN; 00:05 after 50.
//   2. Preload to 59:58 in RUN, run 20 cycles -> 59:59 then 00:00; no stall, running stays 1.
//   3. In RUN at 00:03 press lap -> digits frozen at 00:03 while the live count reaches 00:07.
//      Press lap again -> digits show 00:07 or later; lap_active=0.
//   4. Start, pause at prescaler=6, wait 100 cycles -> count unchanged.
//      Restart -> next tick 4 cycles after RUN re-entry. Then clear in PAUSE -> 00:00, IDLE.
//      Clear pressed in RUN -> ignored.
//   5. Bounce btn_start 1,0,1,0 at 2-cycle spacing, then hold 1 -> exactly one press event; the bounce window issues none.
//   6. Assert rst_n=0 asynchronously mid-RUN at 12:34 -> all outputs 0 before the next edge.
//      Same-cycle clear+start in PAUSE -> IDLE, not RUN.

Source files
------------

// File: rtl/stopwatch_controller.sv
// MM:SS stopwatch sequencer: conditions three raw buttons, runs IDLE/RUN/PAUSE,
// divides clk to a 1 Hz tick and drives a BCD count (or frozen lap value) to the display.
module stopwatch_controller #(
  parameter int TICK_DIV        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       lap_active
);

  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  logic [2:0] raw;
  logic [2:0] press;
  assign raw = {btn_clear, btn_lap, btn_start};

  // Per button: 2-FF synchronizer, stability counter, registered rising-edge pulse.
  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic           s1_q, s2_q, acc_q, acc_d, prs_q, prs_d;
    logic [DBW-1:0] cnt_q, cnt_d;

    always_comb begin
      acc_d = acc_q;
      cnt_d = '0;
      if (s2_q != acc_q) begin
        if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) acc_d = s2_q;
        else                                    cnt_d = cnt_q + 1'b1;
      end
      prs_d = acc_d & ~acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        acc_q <= 1'b0;
        prs_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= raw[b];
        s2_q  <= s1_q;
        acc_q <= acc_d;
        prs_q <= prs_d;
        cnt_q <= cnt_d;
      end
    end

    assign press[b] = prs_q;
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) r[7:4] = v[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
        else begin
          r[11:8]  = 4'd0;
          r[15:12] = (v[15:12] == 4'd5) ? 4'd0 : v[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic          lap_q, lap_d, run_q, run_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d, latch_q, latch_d;
  logic          tick, ev_clear, ev_start, ev_lap;

  // Priority clear > start > lap; losers are dropped.
  assign ev_clear = press[2];
  assign ev_start = press[0] & ~press[2];
  assign ev_lap   = press[1] & ~press[0] & ~press[2];
  assign tick     = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    latch_d = latch_q;
    cnt_d   = tick ? bcd_inc(cnt_q) : cnt_q;
    presc_d = presc_q;
    if (state_q == RUN) presc_d = tick ? '0 : presc_q + 1'b1;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (ev_start) state_d = RUN;
      end
      RUN: begin
        if (ev_start) state_d = PAUSE;
        else if (ev_lap) begin
          lap_d = ~lap_q;
          if (!lap_q) latch_d = cnt_d;
        end
      end
      PAUSE: begin
        if (ev_clear) begin
          state_d = IDLE;
          cnt_d   = '0;
          latch_d = '0;
          lap_d   = 1'b0;
          presc_d = '0;
        end else if (ev_start) state_d = RUN;
        else if (ev_lap && lap_q) lap_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lap_q   <= 1'b0;
      run_q   <= 1'b0;
      presc_q <= '0;
      cnt_q   <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
      run_q   <= run_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

  assign {digit3, digit2, digit1, digit0} = lap_q ? latch_q : cnt_q;
  assign running    = run_q;
  assign lap_active = lap_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with TICK_DIV=10, DEBOUNCE_CYCLES=4.
module tb_stopwatch_controller;

  logic       clk = 1'b0;
  logic       rst_n, btn_start, btn_lap, btn_clear;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running, lap_active;
  logic [15:0] dig;

  int total = 0;
  int bad   = 0;

  stopwatch_controller #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .running(running), .lap_active(lap_active)
  );

  always #5 clk = ~clk;
  assign dig = {digit3, digit2, digit1, digit0};

  typedef struct {
    logic        rn, st, lp, cl;
    int          n;
    logic        run, lap;
    logic [15:0] dig;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rn, logic st, logic lp, logic cl, int n,
                              logic run, logic lap, logic [15:0] d);
    vec_t v;
    v.rn = rn; v.st = st; v.lp = lp; v.cl = cl; v.n = n;
    v.run = run; v.lap = lap; v.dig = d;
    return v;
  endfunction

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic r, input logic l, input logic [15:0] d);
    chk({nm, ".running"}, {15'd0, running}, {15'd0, r});
    chk({nm, ".lap"}, {15'd0, lap_active}, {15'd0, l});
    chk({nm, ".digits"}, dig, d);
  endtask

  task automatic press_start(input int hold, input int after);
    btn_start = 1'b1;
    adv(hold);
    btn_start = 1'b0;
    adv(after);
  endtask

  initial begin
    rst_n = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    adv(2);
    chk_all("reset", 1'b0, 1'b0, 16'h0000);

    // start, tick timing, count to 00:05
    tbl.push_back(mk(1, 1, 0, 0,  5, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0,  9, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0, 16'h0001));
    tbl.push_back(mk(1, 0, 0, 0, 40, 1, 0, 16'h0005));
    // reset, run, lap freeze at 00:03, unfreeze at 00:08
    tbl.push_back(mk(0, 0, 0, 0,  2, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0,  5, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0, 26, 1, 0, 16'h0002));
    tbl.push_back(mk(1, 0, 1, 0,  5, 1, 0, 16'h0003));
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 1, 16'h0003));
    tbl.push_back(mk(1, 0, 0, 0, 40, 1, 1, 16'h0003));
    tbl.push_back(mk(1, 0, 1, 0,  5, 1, 1, 16'h0003));
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 16'h0008));
    // pause with prescaler at 6, hold, resume, clear ignored in RUN, clear in PAUSE
    tbl.push_back(mk(1, 0, 0, 0,  9, 1, 0, 16'h0008));
    tbl.push_back(mk(1, 1, 0, 0,  5, 1, 0, 16'h0009));
    tbl.push_back(mk(1, 0, 0, 0,  2, 0, 0, 16'h0009));
    tbl.push_back(mk(1, 0, 0, 0,100, 0, 0, 16'h0009));
    tbl.push_back(mk(1, 1, 0, 0,  5, 0, 0, 16'h0009));
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 16'h0009));
    tbl.push_back(mk(1, 0, 0, 0,  3, 1, 0, 16'h0009));
    tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0, 16'h0010));
    tbl.push_back(mk(1, 0, 0, 1,  5, 1, 0, 16'h0010));
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 16'h0010));
    tbl.push_back(mk(1, 0, 0, 0,  3, 1, 0, 16'h0011));
    tbl.push_back(mk(1, 1, 0, 0,  5, 1, 0, 16'h0011));
    tbl.push_back(mk(1, 0, 0, 0,  2, 0, 0, 16'h0011));
    tbl.push_back(mk(1, 0, 0, 1,  5, 0, 0, 16'h0011));
    tbl.push_back(mk(1, 0, 0, 0,  2, 0, 0, 16'h0000));
    // restart from IDLE: prescaler must have been zeroed
    tbl.push_back(mk(1, 1, 0, 0,  5, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0,  9, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0, 16'h0001));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rn; btn_start = tbl[i].st; btn_lap = tbl[i].lp; btn_clear = tbl[i].cl;
      adv(tbl[i].n);
      chk_all($sformatf("row%0d", i), tbl[i].run, tbl[i].lap, tbl[i].dig);
    end
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;

    // bounce on start: only the final stable level produces one press
    rst_n = 1'b0;
    adv(2);
    rst_n = 1'b1;
    btn_start = 1'b1; adv(2);
    btn_start = 1'b0; adv(2);
    btn_start = 1'b1; adv(2);
    btn_start = 1'b0; adv(2);
    chk_all("bounce_window", 1'b0, 1'b0, 16'h0000);
    btn_start = 1'b1;
    adv(6);
    chk_all("bounce_before_event", 1'b0, 1'b0, 16'h0000);
    adv(1);
    chk_all("bounce_event", 1'b1, 1'b0, 16'h0000);
    adv(5);
    btn_start = 1'b0;
    adv(20);
    chk_all("bounce_single", 1'b1, 1'b0, 16'h0002);

    // async reset mid-RUN at 12:34
    adv(7520);
    chk_all("at_1234", 1'b1, 1'b0, 16'h1234);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 1'b0, 16'h0000);
    adv(1);
    rst_n = 1'b1;

    // same-cycle clear+start in PAUSE goes to IDLE
    press_start(5, 2);
    chk_all("run_again", 1'b1, 1'b0, 16'h0000);
    adv(30);
    press_start(5, 2);
    chk_all("paused_0003", 1'b0, 1'b0, 16'h0003);
    adv(10);
    btn_start = 1'b1; btn_clear = 1'b1;
    adv(5);
    btn_start = 1'b0; btn_clear = 1'b0;
    adv(2);
    chk_all("clear_beats_start", 1'b0, 1'b0, 16'h0000);
    adv(20);
    chk_all("idle_holds", 1'b0, 1'b0, 16'h0000);

    // wrap 59:59 -> 00:00 without stopping
    rst_n = 1'b0;
    adv(2);
    rst_n = 1'b1;
    press_start(5, 2);
    adv(35985);
    chk_all("at_5958", 1'b1, 1'b0, 16'h5958);
    adv(10);
    chk_all("at_5959", 1'b1, 1'b0, 16'h5959);
    adv(10);
    chk_all("wrap_0000", 1'b1, 1'b0, 16'h0000);
    adv(10);
    chk_all("after_wrap", 1'b1, 1'b0, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
